skip_counter_param: RTL and testbench
=====================================

// Module: skip_counter_param
// PURPOSE
//  Parametrised prescaled up/down counter: advances `out` once every (skip+1) enabled clocks.
//  Generalises the fixed every-other-cycle skip counter: adds programmable width and skip ratio,
//  enable, direction, synchronous load, and step/terminal-count strobes.
//  Used as a rate-divided address/event counter feeding map-decoder logic.
// PARAMETERS
//  WIDTH   13  counter width in bits (>=2)
//  SKIP_W  4   width of the skip-ratio input; ratio range 1..2^SKIP_W
// PORTS
//  clk       in   1        rising-edge clock; the block's only clock
//  reset     in   1        asynchronous, active-low reset (0 = reset)
//  en        in   1        count enable; when 0, phase and out hold
//  skip      in   SKIP_W   idle cycles between steps (0 = step every enabled cycle, 1 = every other)
//  up_dn     in   1        1 = count up, 0 = count down
//  load      in   1        synchronous load strobe
//  load_val  in   WIDTH    value loaded into out when load=1
//  out       out  WIDTH    counter value (registered)
//  tick      out  1        registered 1-cycle pulse, high in the cycle out shows a new stepped value
//  tc        out  1        registered 1-cycle pulse, high with tick when the step crossed a bound
// BEHAVIOUR
//  - reset=0 (asynchronous, no clock needed): out=0, phase=0, tick=0, tc=0.
//  - Priority at each clock edge: load > en > hold.
//  - load=1: out<=load_val, phase<=0, tick<=0, tc<=0 (en is ignored).
//  - en=1, load=0: step when phase==0. Next phase = (phase>=skip) ? 0 : phase+1.
//    The first enabled cycle after reset or load therefore steps.
//  - Step up: out<=out+1. Step down: out<=out-1. Modulo 2^WIDTH; no carry output.
//  - tick<=1 on the edge that steps. tc<=1 on the same edge if up at all-ones or down at 0.
//    Both are 0 on every other edge, including en=0 edges.
//  - skip change mid-run: takes effect at once. If phase > new skip, phase returns to 0 on the next enabled edge.
//  - up_dn change: sampled at the edge that steps; it never disturbs phase.
//  - Latency: 1 clock from the stepping edge to the new out/tick/tc.
// CONFIGURATION
//  SKIP_CNT_SATURATE_EN defined: out does not wrap. A step up at all-ones, or down at 0, leaves out unchanged.
//    tick and tc still pulse for that step.
//  Not defined: modulo wrap as above (all-ones -> 0 up, 0 -> all-ones down).
// STRUCTURE
//  Package skip_cnt_pkg:
//    localparams DIR_UP=1'b1, DIR_DOWN=1'b0.
//    Default widths CNT_W_DEF=13, SKIP_W_DEF=4.
//  Sub-module skip_phase_gen (clk, reset, en, load, skip -> step):
//    owns the phase register and the phase/step logic.
//    step is combinational: en & ~load & (phase==0).
//  Top level: counter register, direction/wrap/saturate logic, tick/tc registers.
// TESTING
//  1. WIDTH=13, skip=1, up, en=1 after reset release -> out 1,1,2,2,3,3; tick 1,0,1,0,1,0.
//  2. skip=0 -> out +1 every cycle, tick stays 1. skip=3 -> out +1 every 4th cycle.
//  3. WIDTH=4, load 14, then skip=0 up -> out 15 then 0 with tc=1 (SKIP_CNT_SATURATE_EN: holds 15, tc=1).
//  4. WIDTH=4, out=0, up_dn=0, skip=0 -> out 15 with tc=1 (saturate build: stays 0, tc=1).
//  5. load_val=100 mid-phase with en=1 -> out=100, tick=0; next edge out=101, tick=1.
//     en=0 for 3 cycles -> out and phase frozen.
//  6. reset=0 driven between clock edges mid-count -> out=0, tick=tc=0 with no clock edge.
//     First edge after release steps to 1.

Source files
------------

// File: rtl/skip_counter_param_pkg.sv
// rtl/skip_counter_param_pkg.sv - shared constants for the prescaled skip counter
package skip_cnt_pkg;

    // Direction encoding of up_dn
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Default widths
    localparam int CNT_W_DEF  = 13;
    localparam int SKIP_W_DEF = 4;

endpackage

// File: rtl/skip_counter_param_if.sv
// rtl/skip_counter_param_if.sv - control/status bundle of the prescaled skip counter
interface skip_counter_param_if
    import skip_cnt_pkg::*;
#(
    parameter int WIDTH  = CNT_W_DEF,
    parameter int SKIP_W = SKIP_W_DEF
);
    logic              en;
    logic [SKIP_W-1:0] skip;
    logic              up_dn;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  out;
    logic              tick;
    logic              tc;

    modport master (
        output en, skip, up_dn, load, load_val,
        input  out, tick, tc
    );

    modport slave (
        input  en, skip, up_dn, load, load_val,
        output out, tick, tc
    );
endinterface

// File: rtl/skip_phase_gen.sv
// rtl/skip_phase_gen.sv - phase register deciding which enabled cycles step the counter
module skip_phase_gen
    import skip_cnt_pkg::*;
#(
    parameter int SKIP_W = SKIP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [SKIP_W-1:0] skip,
    output logic              step
);
    logic [SKIP_W-1:0] phase;

    // Phase runs 0..skip while enabled; load restarts it so the next enabled cycle steps.
    // Comparing with >= lets a shrinking skip pull an out-of-range phase back to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (load) begin
            phase <= '0;
        end else if (en) begin
            phase <= (phase >= skip) ? '0 : phase + SKIP_W'(1);
        end
    end

    assign step = en & ~load & (phase == '0);
endmodule

// File: rtl/skip_counter_param.sv
// rtl/skip_counter_param.sv - prescaled up/down counter; SKIP_CNT_SATURATE_EN selects saturate instead of wrap
module skip_counter_param
    import skip_cnt_pkg::*;
#(
    parameter int WIDTH  = CNT_W_DEF,
    parameter int SKIP_W = SKIP_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    skip_counter_param_if.slave   bus
);
    logic             step;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_stepped;
    logic [WIDTH-1:0] cnt_next;
    logic             at_bound;
    logic             tick_q;
    logic             tc_q;

    skip_phase_gen #(.SKIP_W(SKIP_W)) u_phase (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en),
        .load  (bus.load),
        .skip  (bus.skip),
        .step  (step)
    );

    // Value the counter takes if this edge steps, including the bound crossing detect
    always_comb begin
        at_bound    = (bus.up_dn == DIR_UP) ? (&cnt) : (cnt == '0);
        cnt_stepped = (bus.up_dn == DIR_UP) ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
`ifdef SKIP_CNT_SATURATE_EN
        cnt_next    = at_bound ? cnt : cnt_stepped;
`else
        cnt_next    = cnt_stepped;
`endif
    end

    // Counter and strobes: load beats step; strobes are cleared on every non-stepping edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
        end else if (bus.load) begin
            cnt    <= bus.load_val;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
        end else if (step) begin
            cnt    <= cnt_next;
            tick_q <= 1'b1;
            tc_q   <= at_bound;
        end else begin
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
        end
    end

    assign bus.out  = cnt;
    assign bus.tick = tick_q;
    assign bus.tc   = tc_q;
endmodule

// File: tb/tb_skip_counter_param.sv
// tb/tb_skip_counter_param.sv - self-checking bench for skip_counter_param (13-bit and 4-bit instances)
module tb_skip_counter_param;
`ifdef SKIP_CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_on = 1'b0;

    int m_out [2];
    int m_ph  [2];
    int m_tick[2];
    int m_tc  [2];

    skip_counter_param_if #(.WIDTH(13), .SKIP_W(4)) bus13 ();
    skip_counter_param_if #(.WIDTH(4),  .SKIP_W(4)) bus4 ();

    skip_counter_param #(.WIDTH(13), .SKIP_W(4)) dut13 (.clk(clk), .reset(reset), .bus(bus13.slave));
    skip_counter_param #(.WIDTH(4),  .SKIP_W(4)) dut4  (.clk(clk), .reset(reset), .bus(bus4.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a counter of modulus 2^w that steps on every (skip+1)-th enabled cycle
    task automatic model_edge(input int i, input bit e, input int sk, input bit up,
                              input bit ld, input int lv, input int maxv);
        bit bound;
        if (ld) begin
            m_out[i] = lv; m_ph[i] = 0; m_tick[i] = 0; m_tc[i] = 0;
        end else if (e) begin
            if (m_ph[i] == 0) begin
                bound     = up ? (m_out[i] == maxv) : (m_out[i] == 0);
                m_tick[i] = 1;
                m_tc[i]   = bound ? 1 : 0;
                if (!(SAT && bound))
                    m_out[i] = up ? (m_out[i] + 1) % (maxv + 1) : (m_out[i] + maxv) % (maxv + 1);
            end else begin
                m_tick[i] = 0; m_tc[i] = 0;
            end
            m_ph[i] = (m_ph[i] >= sk) ? 0 : m_ph[i] + 1;
        end else begin
            m_tick[i] = 0; m_tc[i] = 0;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_out[i] = 0; m_ph[i] = 0; m_tick[i] = 0; m_tc[i] = 0;
            end
        end else begin
            model_edge(0, bus13.en, int'(bus13.skip), bus13.up_dn, bus13.load, int'(bus13.load_val), 8191);
            model_edge(1, bus4.en,  int'(bus4.skip),  bus4.up_dn,  bus4.load,  int'(bus4.load_val),  15);
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("m13_out",  int'(bus13.out),  m_out[0]);
            chk("m13_tick", int'(bus13.tick), m_tick[0]);
            chk("m13_tc",   int'(bus13.tc),   m_tc[0]);
            chk("m4_out",   int'(bus4.out),   m_out[1]);
            chk("m4_tick",  int'(bus4.tick),  m_tick[1]);
            chk("m4_tc",    int'(bus4.tc),    m_tc[1]);
        end
    end

    task automatic drv(input bit e, input int sk, input bit ud, input bit ld, input int lv13, input int lv4);
        bus13.en = e; bus13.skip = sk[3:0]; bus13.up_dn = ud; bus13.load = ld; bus13.load_val = lv13[12:0];
        bus4.en  = e; bus4.skip  = sk[3:0]; bus4.up_dn  = ud; bus4.load  = ld; bus4.load_val  = lv4[3:0];
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    int e1_out [6] = '{1, 1, 2, 2, 3, 3};
    int e1_tick[6] = '{1, 0, 1, 0, 1, 0};

    initial begin
        drv(0, 0, 1, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out13", int'(bus13.out), 0);
        chk("rst_tick13", int'(bus13.tick), 0);
        chk("rst_tc13", int'(bus13.tc), 0);
        chk("rst_out4", int'(bus4.out), 0);
        cmp_on = 1'b1;

        // 1: skip=1 counting up straight out of reset
        @(posedge clk); #2;
        reset = 1'b1;
        drv(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t1_out", int'(bus13.out), e1_out[i]);
            chk("t1_tick", int'(bus13.tick), e1_tick[i]);
        end

        // 2: skip=0 steps each cycle, skip=3 every fourth
        drv(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t2_skip0_out", int'(bus13.out), 4 + i);
            chk("t2_skip0_tick", int'(bus13.tick), 1);
        end
        drv(1, 3, 1, 0, 0, 0);
        cyc(); chk("t2_skip3_e1", int'(bus13.out), 8);
        repeat (3) cyc();
        chk("t2_skip3_e4", int'(bus13.out), 8);
        chk("t2_skip3_e4_tick", int'(bus13.tick), 0);
        cyc(); chk("t2_skip3_e5", int'(bus13.out), 9);
        chk("t2_skip3_e5_tick", int'(bus13.tick), 1);
        repeat (3) cyc();

        // skip shrinks while phase is beyond it
        repeat (3) cyc();
        chk("skipchg_pre", int'(bus13.out), 10);
        drv(1, 1, 1, 0, 0, 0);
        cyc(); chk("skipchg_hold", int'(bus13.out), 10);
        cyc(); chk("skipchg_step", int'(bus13.out), 11);

        // 3: wrap/saturate at all-ones going up
        drv(1, 0, 1, 1, 8190, 14);
        cyc(); chk("t3_load4", int'(bus4.out), 14); chk("t3_load_tick", int'(bus4.tick), 0);
        drv(1, 0, 1, 0, 0, 0);
        cyc(); chk("t3_s1_out4", int'(bus4.out), 15); chk("t3_s1_tc4", int'(bus4.tc), 0);
        chk("t3_s1_out13", int'(bus13.out), 8191);
        cyc(); chk("t3_s2_out4", int'(bus4.out), SAT ? 15 : 0); chk("t3_s2_tc4", int'(bus4.tc), 1);
        chk("t3_s2_out13", int'(bus13.out), SAT ? 8191 : 0); chk("t3_s2_tc13", int'(bus13.tc), 1);

        // 4: wrap/saturate at zero going down
        drv(1, 0, 0, 1, 0, 0);
        cyc();
        drv(1, 0, 0, 0, 0, 0);
        cyc(); chk("t4_out4", int'(bus4.out), SAT ? 0 : 15); chk("t4_tc4", int'(bus4.tc), 1);
        chk("t4_out13", int'(bus13.out), SAT ? 0 : 8191);
        cyc(); chk("t4_next_tc4", int'(bus4.tc), SAT ? 1 : 0);

        // 5: load mid-phase, then freeze with en=0
        drv(1, 3, 1, 0, 0, 0);
        repeat (2) cyc();
        drv(1, 3, 1, 1, 100, 4);
        cyc(); chk("t5_load_out", int'(bus13.out), 100); chk("t5_load_tick", int'(bus13.tick), 0);
        drv(1, 3, 1, 0, 0, 0);
        cyc(); chk("t5_step_out", int'(bus13.out), 101); chk("t5_step_tick", int'(bus13.tick), 1);
        drv(0, 3, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); chk("t5_frozen_out", int'(bus13.out), 101); chk("t5_frozen_tick", int'(bus13.tick), 0);
        end
        drv(1, 3, 1, 0, 0, 0);
        repeat (3) cyc();
        chk("t5_resume_hold", int'(bus13.out), 101);
        cyc(); chk("t5_resume_step", int'(bus13.out), 102);

        // 6: asynchronous reset between edges
        #2 reset = 1'b0;
        #1;
        chk("t6_async_out13", int'(bus13.out), 0);
        chk("t6_async_tick13", int'(bus13.tick), 0);
        chk("t6_async_tc13", int'(bus13.tc), 0);
        chk("t6_async_out4", int'(bus4.out), 0);
        @(posedge clk); #2;
        reset = 1'b1;
        drv(1, 0, 1, 0, 0, 0);
        cyc(); chk("t6_first_out", int'(bus13.out), 1); chk("t6_first_tick", int'(bus13.tick), 1);
        cyc();

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
